// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared widths, FSM states and address field helpers for the read cache
package cache_pkg;

  localparam int INDEX_W = 6;
  localparam int TAG_W   = 10;
  localparam int SETS    = 64;

  typedef logic [1:0] state_t;

  localparam state_t IDLE      = 2'd0;
  localparam state_t READ_MISS = 2'd1;
  localparam state_t WRITE     = 2'd2;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [31:0] a);
    return a[18:9];
  endfunction

  function automatic logic [INDEX_W-1:0] addr_index(input logic [31:0] a);
    return a[8:3];
  endfunction

  function automatic logic addr_offset(input logic [31:0] a);
    return a[2];
  endfunction

  // Offset 0 is the low word of the block, offset 1 the high word.
  function automatic logic [31:0] select_word(input logic [63:0] blk, input logic off);
    return off ? blk[63:32] : blk[31:0];
  endfunction

  function automatic logic [63:0] merge_word(input logic [63:0] blk, input logic [31:0] word,
                                             input logic off);
    return off ? {word, blk[31:0]} : {blk[63:32], word};
  endfunction

endpackage

// File: rtl/cache_way_array.sv
// rtl/cache_way_array.sv - one way of valid/tag/data storage with async-cleared valid bits
module cache_way_array
  import cache_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [63:0]        rd_data,
  input  logic               wr_en,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [63:0]        wr_data
);

  logic [SETS-1:0]  valid_q;
  logic [TAG_W-1:0] tag_mem  [SETS];
  logic [63:0]      data_mem [SETS];

  // Valid bits: cleared by reset, set by any write (fill or word update).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  // Tag and data storage; contents are only trusted behind a valid bit, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_data  = data_mem[rd_index];

endmodule

// File: rtl/cache_controller.sv
// rtl/cache_controller.sv - two-way set-associative write-through read cache in front of the SRAM controller
module cache_controller
  import cache_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        freeze,
  output logic        sram_wr_en_n,
  output logic        sram_rd_en_n,
  output logic        sram_hit,
  output logic [31:0] sram_address,
  output logic [31:0] sram_wdata,
  input  logic [63:0] sram_rdata,
  input  logic        sram_pause,
  input  logic        sram_ready
);

  state_t state_q, state_d;
  logic [SETS-1:0] lru_q;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic               off;

  logic               v0, v1;
  logic [TAG_W-1:0]   t0, t1;
  logic [63:0]        d0, d1;
  logic               hit0, hit1, hit;
  logic [63:0]        hit_block;
  logic               victim;

  logic               fill_en, upd_en;
  logic               lru_we, lru_val;
  logic               we0, we1;
  logic [63:0]        wd0, wd1;

  assign idx = addr_index(address);
  assign tag = addr_tag(address);
  assign off = addr_offset(address);

  assign sram_address = address;
  assign sram_wdata   = wdata;

  cache_way_array u_way0 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx),
    .rd_valid (v0),
    .rd_tag   (t0),
    .rd_data  (d0),
    .wr_en    (we0),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_data  (wd0)
  );

  cache_way_array u_way1 (
    .clk      (clk),
    .rst      (rst),
    .rd_index (idx),
    .rd_valid (v1),
    .rd_tag   (t1),
    .rd_data  (d1),
    .wr_en    (we1),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_data  (wd1)
  );

  // Way0 takes priority so a (never expected) double match still selects one way.
  assign hit0      = v0 && (t0 == tag);
  assign hit1      = v1 && (t1 == tag) && !hit0;
  assign hit       = hit0 || hit1;
  assign hit_block = hit0 ? d0 : d1;
  assign victim    = lru_q[idx];

  // A fill replaces the LRU way with the whole block; a write hit merges one word into the hit way.
  assign we0 = (fill_en && !victim) || (upd_en && hit0);
  assign we1 = (fill_en &&  victim) || (upd_en && hit1);
  assign wd0 = fill_en ? sram_rdata : merge_word(d0, wdata, off);
  assign wd1 = fill_en ? sram_rdata : merge_word(d1, wdata, off);

  // Request decode and handshake outputs; reset forces everything idle without waiting for a clock.
  always_comb begin
    state_d      = state_q;
    freeze       = 1'b0;
    sram_rd_en_n = 1'b1;
    sram_wr_en_n = 1'b1;
    sram_hit     = 1'b0;
    rdata        = '0;
    fill_en      = 1'b0;
    upd_en       = 1'b0;
    lru_we       = 1'b0;
    lru_val      = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (MEM_W_EN) begin
            freeze       = 1'b1;
            sram_wr_en_n = 1'b0;
            state_d      = WRITE;
          end else if (MEM_R_EN) begin
            if (hit) begin
              rdata    = select_word(hit_block, off);
              sram_hit = 1'b1;
              lru_we   = 1'b1;
              lru_val  = hit0;
            end else begin
              freeze       = 1'b1;
              sram_rd_en_n = 1'b0;
              state_d      = READ_MISS;
            end
          end
        end
        READ_MISS: begin
          sram_rd_en_n = 1'b0;
          if (sram_ready) begin
            rdata   = select_word(sram_rdata, off);
            fill_en = 1'b1;
            lru_we  = 1'b1;
            lru_val = !victim;
            state_d = IDLE;
          end else begin
            freeze = 1'b1;
          end
        end
        WRITE: begin
          sram_wr_en_n = 1'b0;
          if (!sram_pause) begin
            state_d = IDLE;
            if (hit) begin
              upd_en  = 1'b1;
              lru_we  = 1'b1;
              lru_val = hit0;
            end
          end else begin
            freeze = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Per-set LRU bit names the next victim way; any access points it at the other way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lru_q <= '0;
    end else if (lru_we) begin
      lru_q[idx] <= lru_val;
    end
  end

endmodule

// File: tb/tb_cache_controller.sv
// tb/tb_cache_controller.sv - self-checking bench for cache_controller with a behavioural cache model
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        MEM_R_EN, MEM_W_EN;
  logic [31:0] address, wdata;
  logic [31:0] rdata;
  logic        freeze, sram_wr_en_n, sram_rd_en_n, sram_hit;
  logic [31:0] sram_address, sram_wdata;
  logic [63:0] sram_rdata;
  logic        sram_pause, sram_ready;

  int n_vec = 0;
  int n_err = 0;

  cache_controller dut (
    .clk          (clk),
    .rst          (rst),
    .MEM_R_EN     (MEM_R_EN),
    .MEM_W_EN     (MEM_W_EN),
    .address      (address),
    .wdata        (wdata),
    .rdata        (rdata),
    .freeze       (freeze),
    .sram_wr_en_n (sram_wr_en_n),
    .sram_rd_en_n (sram_rd_en_n),
    .sram_hit     (sram_hit),
    .sram_address (sram_address),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata),
    .sram_pause   (sram_pause),
    .sram_ready   (sram_ready)
  );

  always #5 clk = ~clk;

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0b expected %0b at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, got, exp, $time);
    end
  endtask

  // Behavioural model: two ways of 64 sets, victim way per set, outstanding-request kind.
  int          m_v   [2][64];
  int          m_t   [2][64];
  logic [63:0] m_d   [2][64];
  int          m_lru [64];
  int          m_busy = 0;            // 0 none, 1 read waiting for SRAM, 2 write waiting for SRAM

  localparam int A_NONE = 0, A_TOUCH = 1, A_START_R = 2, A_START_W = 3, A_FILL = 4, A_WDONE = 5;
  int          act = A_NONE;
  int          act_way;
  logic [31:0] act_addr, act_wdata;
  logic [63:0] act_blk;

  function automatic int set_of(input logic [31:0] a);
    return int'((a / 32'd8) % 32'd64);
  endfunction

  function automatic int tag_of(input logic [31:0] a);
    return int'((a / 32'd512) % 32'd1024);
  endfunction

  function automatic logic [31:0] word_of(input logic [63:0] blk, input logic [31:0] a);
    logic [63:0] b;
    b = blk;
    if (((a / 32'd4) % 32'd2) == 32'd1) return b[63:32];
    return b[31:0];
  endfunction

  function automatic int lookup(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (m_v[w][set_of(a)] != 0 && m_t[w][set_of(a)] == tag_of(a)) return w;
    return -1;
  endfunction

  logic        e_frz, e_rdn, e_wrn, e_hit;
  logic [31:0] e_rdata;
  int          w_n;

  // Compare process: derive expected outputs from the model and inputs, record the pending update.
  always @(negedge clk) begin
    e_frz = 1'b0; e_rdn = 1'b1; e_wrn = 1'b1; e_hit = 1'b0; e_rdata = '0;
    act = A_NONE;
    if (!rst) begin
      if (m_busy == 0) begin
        if (MEM_W_EN) begin
          e_frz = 1'b1; e_wrn = 1'b0; act = A_START_W;
        end else if (MEM_R_EN) begin
          w_n = lookup(address);
          if (w_n >= 0) begin
            e_rdata = word_of(m_d[w_n][set_of(address)], address);
            e_hit = 1'b1; act = A_TOUCH; act_way = w_n;
          end else begin
            e_frz = 1'b1; e_rdn = 1'b0; act = A_START_R;
          end
        end
      end else if (m_busy == 1) begin
        e_rdn = 1'b0;
        if (sram_ready) begin
          e_rdata = word_of(sram_rdata, address); act = A_FILL;
        end else begin
          e_frz = 1'b1;
        end
      end else begin
        e_wrn = 1'b0;
        if (!sram_pause) act = A_WDONE;
        else e_frz = 1'b1;
      end
    end
    act_addr = address; act_wdata = wdata; act_blk = sram_rdata;
    chk1("freeze", freeze, e_frz);
    chk1("sram_rd_en_n", sram_rd_en_n, e_rdn);
    chk1("sram_wr_en_n", sram_wr_en_n, e_wrn);
    chk1("sram_hit", sram_hit, e_hit);
    chk32("sram_address", sram_address, address);
    chk32("sram_wdata", sram_wdata, wdata);
    if (rst || (!MEM_W_EN && (!MEM_R_EN || !e_frz))) chk32("rdata", rdata, e_rdata);
  end

  int i_p, w_p;

  // Model update at the clock edge.
  always @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < 64; s++) begin
        m_v[0][s] = 0; m_v[1][s] = 0; m_lru[s] = 0;
      end
      m_busy = 0;
    end else begin
      i_p = set_of(act_addr);
      case (act)
        A_TOUCH:   m_lru[i_p] = (act_way == 0) ? 1 : 0;
        A_START_R: m_busy = 1;
        A_START_W: m_busy = 2;
        A_FILL: begin
          w_p = m_lru[i_p];
          m_v[w_p][i_p] = 1;
          m_t[w_p][i_p] = tag_of(act_addr);
          m_d[w_p][i_p] = act_blk;
          m_lru[i_p] = (w_p == 0) ? 1 : 0;
          m_busy = 0;
        end
        A_WDONE: begin
          w_p = lookup(act_addr);
          if (w_p >= 0) begin
            if (((act_addr / 32'd4) % 32'd2) == 32'd1) m_d[w_p][i_p][63:32] = act_wdata;
            else m_d[w_p][i_p][31:0] = act_wdata;
            m_lru[i_p] = (w_p == 0) ? 1 : 0;
          end
          m_busy = 0;
        end
        default: ;
      endcase
    end
    act = A_NONE;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] a, input bit miss, input int lat,
                    input logic [63:0] blk, input logic [31:0] exp_w);
    address = a; MEM_R_EN = 1'b1; MEM_W_EN = 1'b0;
    if (miss) begin
      @(negedge clk);
      chk1("miss_freeze", freeze, 1'b1);
      chk1("miss_rd_en_n", sram_rd_en_n, 1'b0);
      cyc();
      repeat (lat) cyc();
      sram_rdata = blk; sram_ready = 1'b1;
      @(negedge clk);
      chk32("fill_rdata", rdata, exp_w);
      chk1("fill_freeze", freeze, 1'b0);
      cyc();
      sram_ready = 1'b0; sram_rdata = '0;
    end else begin
      @(negedge clk);
      chk32("hit_rdata", rdata, exp_w);
      chk1("hit_sram_hit", sram_hit, 1'b1);
      chk1("hit_freeze", freeze, 1'b0);
      chk1("hit_rd_en_n", sram_rd_en_n, 1'b1);
      cyc();
    end
    MEM_R_EN = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input int pause, input bit both);
    address = a; wdata = d; MEM_W_EN = 1'b1; MEM_R_EN = both;
    @(negedge clk);
    chk1("wr_start_freeze", freeze, 1'b1);
    chk1("wr_start_wr_en_n", sram_wr_en_n, 1'b0);
    cyc();
    sram_pause = (pause > 0);
    for (int k = 0; k < pause; k++) begin
      @(negedge clk);
      chk1("wr_hold_freeze", freeze, 1'b1);
      chk1("wr_hold_wr_en_n", sram_wr_en_n, 1'b0);
      cyc();
      if (k == pause - 1) sram_pause = 1'b0;
    end
    @(negedge clk);
    chk1("wr_done_freeze", freeze, 1'b0);
    chk1("wr_done_wr_en_n", sram_wr_en_n, 1'b0);
    cyc();
    MEM_W_EN = 1'b0; MEM_R_EN = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; address = '0; wdata = '0;
    sram_rdata = '0; sram_pause = 1'b0; sram_ready = 1'b0;
    cyc();
    @(negedge clk);
    chk1("reset_freeze", freeze, 1'b0);
    chk1("reset_rd_en_n", sram_rd_en_n, 1'b1);
    chk1("reset_wr_en_n", sram_wr_en_n, 1'b1);
    chk1("reset_sram_hit", sram_hit, 1'b0);
    chk32("reset_rdata", rdata, 32'h0);
    cyc();
    rst = 1'b0;
    cyc();

    rd(32'h0000_0010, 1'b1, 1, 64'h22222222_11111111, 32'h11111111);
    rd(32'h0000_0014, 1'b0, 0, 64'h0, 32'h22222222);
    rd(32'h0000_0210, 1'b1, 0, 64'h44444444_33333333, 32'h33333333);
    rd(32'h0000_0410, 1'b1, 2, 64'h66666666_55555555, 32'h55555555);
    rd(32'h0000_0214, 1'b0, 0, 64'h0, 32'h44444444);
    rd(32'h0000_0010, 1'b1, 0, 64'h22222222_11111111, 32'h11111111);
    wr(32'h0000_0014, 32'hDEADBEEF, 2, 1'b0);
    rd(32'h0000_0014, 1'b0, 0, 64'h0, 32'hDEADBEEF);
    rd(32'h0000_0010, 1'b0, 0, 64'h0, 32'h11111111);
    cyc();
    cyc();
    wr(32'h0000_0818, 32'hCAFEF00D, 1, 1'b0);
    rd(32'h0000_0818, 1'b1, 0, 64'h88888888_77777777, 32'h77777777);
    rd(32'h0000_0214, 1'b0, 0, 64'h0, 32'h44444444);
    wr(32'h0000_0210, 32'h0BADF00D, 0, 1'b1);
    rd(32'h0000_0210, 1'b0, 0, 64'h0, 32'h0BADF00D);
    rd(32'h0000_0214, 1'b0, 0, 64'h0, 32'h44444444);

    address = 32'h0000_1000; MEM_R_EN = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;
    #1;
    chk1("abort_rd_en_n", sram_rd_en_n, 1'b1);
    chk1("abort_freeze", freeze, 1'b0);
    cyc();
    cyc();
    MEM_R_EN = 1'b0; rst = 1'b0;
    cyc();
    rd(32'h0000_0010, 1'b1, 0, 64'h22222222_11111111, 32'h11111111);
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
